// File: rtl/inst_fetch_resp_pkg.sv
// Shared definitions for the instruction-fetch responder: bus widths,
// reset polarity and the fetch FSM state encoding.
package inst_fetch_resp_pkg;

  localparam int unsigned InstMemAddrW = 17;
  localparam int unsigned InstAddrBus  = 32;
  localparam int unsigned InstBus      = 32;

  localparam logic              RstActiveLow = 1'b0;
  localparam logic [InstBus-1:0] ZeroWord    = '0;

  typedef enum logic [1:0] {
    FetchIdle = 2'b00,
    FetchBusy = 2'b01,
    FetchLast = 2'b10,
    FetchDone = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: reads four byte beats from a fixed-latency
// byte-wide RAM, assembles a little-endian 32-bit instruction and stalls the
// PC stage until the instruction is handed to decode.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = InstMemAddrW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [InstAddrBus-1:0] pc,
  input  logic                   ce,
  output logic [InstBus-1:0]     inst,
  output logic                   inst_valid,
  output logic                   stall_req,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_rd,
  input  logic [7:0]             mem_din
);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] pc_q;
  logic [3:0][7:0]   lanes_q;

  // pc bits above the RAM window are ignored; lane 3 is bypassed straight
  // into inst on the LAST edge, so its register is never read back.
  logic unused_bits;
  assign unused_bits = ^{pc[InstAddrBus-1:ADDR_W], lanes_q[3]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RstActiveLow) begin
      state_q <= FetchIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and outputs decoded from registered state/cnt only.
  always_comb begin
    state_d    = state_q;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    stall_req  = 1'b0;
    inst_valid = 1'b0;
    unique case (state_q)
      FetchIdle: begin
        if (ce) state_d = FetchBusy;
      end
      FetchBusy: begin
        mem_rd    = 1'b1;
        mem_addr  = pc_q + ADDR_W'(cnt_q);
        stall_req = 1'b1;
        if (!ce)                state_d = FetchIdle;
        else if (cnt_q == 2'd3) state_d = FetchLast;
      end
      FetchLast: begin
        stall_req = 1'b1;
        state_d   = ce ? FetchDone : FetchIdle;
      end
      FetchDone: begin
        inst_valid = 1'b1;
        state_d    = FetchIdle;
      end
      default: state_d = FetchIdle;
    endcase
  end

  // Request latch, beat counter, byte-lane capture and instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RstActiveLow) begin
      cnt_q   <= '0;
      pc_q    <= '0;
      lanes_q <= '0;
      inst    <= ZeroWord;
    end else begin
      unique case (state_q)
        FetchIdle: begin
          if (ce) begin
            pc_q    <= pc[ADDR_W-1:0];
            cnt_q   <= '0;
            lanes_q <= '0;
          end
        end
        FetchBusy: begin
          // Read data lags the strobe by one cycle, so beat cnt-1 arrives now.
          if (cnt_q != 2'd0) lanes_q[cnt_q - 2'd1] <= mem_din;
          if (cnt_q != 2'd3) cnt_q <= cnt_q + 2'd1;
        end
        FetchLast: begin
          if (ce) begin
            lanes_q[3] <= mem_din;
            inst       <= {mem_din, lanes_q[2], lanes_q[1], lanes_q[0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Directed bench for inst_fetch_resp with a byte-wide RAM model and a
// scoreboard of expected instructions.
module tb_inst_fetch_resp;
  import inst_fetch_resp_pkg::*;

  localparam int unsigned AW = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   pc;
  logic          ce;
  logic [31:0]   inst;
  logic          inst_valid;
  logic          stall_req;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_din = 8'h00;

  logic [7:0]    ram [0:(1<<AW)-1];
  logic [31:0]   exp_q [$];
  int unsigned   total = 0;
  int unsigned   passed = 0;
  int unsigned   cyc = 0;
  int unsigned   last_valid_cyc = 0;
  int unsigned   first_cyc;
  logic [31:0]   prev_inst;

  inst_fetch_resp #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .ce         (ce),
    .inst       (inst),
    .inst_valid (inst_valid),
    .stall_req  (stall_req),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_din    (mem_din)
  );

  always #5 clk = ~clk;

  // RAM model: data for a read strobe appears one cycle later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_din <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a fetch in the current (IDLE) cycle and checks T1..T6.
  task automatic do_fetch(input logic [31:0] p, input bit wiggle, input string tag);
    logic [AW-1:0] base;
    logic [AW-1:0] ea;
    logic [31:0]   e;
    base = p[AW-1:0];
    e = {ram[AW'(base + 3)], ram[AW'(base + 2)], ram[AW'(base + 1)], ram[base]};
    exp_q.push_back(e);
    chk({tag, " t0 stall"}, {31'd0, stall_req}, 32'd0);
    chk({tag, " t0 rd"},    {31'd0, mem_rd},    32'd0);
    ce = 1'b1;
    pc = p;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (wiggle && k <= 5) pc = $urandom;
      ea = base + AW'(k - 1);
      chk($sformatf("%s t%0d stall", tag, k), {31'd0, stall_req}, {31'd0, (k <= 5)});
      chk($sformatf("%s t%0d rd", tag, k),    {31'd0, mem_rd},    {31'd0, (k <= 4)});
      chk($sformatf("%s t%0d addr", tag, k),  32'(mem_addr),      (k <= 4) ? 32'(ea) : 32'd0);
      chk($sformatf("%s t%0d valid", tag, k), {31'd0, inst_valid}, {31'd0, (k == 6)});
      if (inst_valid === 1'b1) begin
        chk({tag, " sb depth"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) chk({tag, " inst"}, inst, exp_q.pop_front());
        last_valid_cyc = cyc;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ce    = 1'b0;
    pc    = '0;
    for (int unsigned i = 0; i < (1 << AW); i++) ram[i] = 8'($urandom);

    // Reset state
    repeat (3) step();
    chk("rst inst",  inst, 32'd0);
    chk("rst valid", {31'd0, inst_valid}, 32'd0);
    chk("rst stall", {31'd0, stall_req}, 32'd0);
    chk("rst rd",    {31'd0, mem_rd}, 32'd0);
    chk("rst addr",  32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic fetch then back-to-back fetch from 4
    ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h00; ram[3] = 8'h00;
    ram[4] = 8'h93; ram[5] = 8'h05; ram[6] = 8'h10; ram[7] = 8'h00;
    do_fetch(32'h0, 1'b0, "basic");
    chk("basic literal", inst, 32'h0000_0513);
    first_cyc = last_valid_cyc;
    pc = 32'h4;
    step();
    do_fetch(32'h4, 1'b0, "b2b");
    chk("b2b literal", inst, 32'h0010_0593);
    chk("b2b spacing", last_valid_cyc - first_cyc, 32'd7);
    step();

    // Wrap-around at the top of the RAM window
    ram[17'h1FFFE] = 8'hAA; ram[17'h1FFFF] = 8'hBB; ram[0] = 8'hCC; ram[1] = 8'hDD;
    do_fetch(32'h0001_FFFE, 1'b0, "wrap");
    chk("wrap literal", inst, 32'hDDCC_BBAA);
    step();

    // Abort: ce dropped during T3
    prev_inst = inst;
    ram[8] = 8'h37; ram[9] = 8'h45; ram[10] = 8'h23; ram[11] = 8'h01;
    ce = 1'b1;
    pc = 32'h8;
    step();
    chk("abort t1 rd", {31'd0, mem_rd}, 32'd1);
    step();
    step();
    chk("abort t3 addr", 32'(mem_addr), 32'hA);
    ce = 1'b0;
    step();
    chk("abort t4 rd",    {31'd0, mem_rd}, 32'd0);
    chk("abort t4 stall", {31'd0, stall_req}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("abort valid %0d", k), {31'd0, inst_valid}, 32'd0);
      chk($sformatf("abort inst %0d", k), inst, prev_inst);
      step();
    end

    // Asynchronous reset in the middle of T2
    ce = 1'b1;
    pc = 32'h20;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst inst",  inst, 32'd0);
    chk("arst valid", {31'd0, inst_valid}, 32'd0);
    chk("arst stall", {31'd0, stall_req}, 32'd0);
    chk("arst rd",    {31'd0, mem_rd}, 32'd0);
    chk("arst addr",  32'(mem_addr), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    do_fetch(32'h8, 1'b0, "post-rst");
    chk("post-rst literal", inst, 32'h0123_4537);
    step();

    // pc wiggles while stalled; upper pc bits ignored
    ram[17'h100] = 8'h67; ram[17'h101] = 8'h80; ram[17'h102] = 8'h00; ram[17'h103] = 8'h00;
    do_fetch(32'hFFF0_0100, 1'b1, "stable");
    chk("stable literal", inst, 32'h0000_8067);
    ce = 1'b0;
    step();
    step();
    chk("idle valid", {31'd0, inst_valid}, 32'd0);
    chk("sb drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inst_fetch_resp.md
# inst_fetch_resp

Instruction-fetch responder on the memory side of the PC stage. Accepts a fetch request (`pc`, `ce`) from the PC stage. Reads the instruction as four byte beats from a byte-wide, fixed-latency instruction RAM and assembles a little-endian 32-bit RISC-V instruction. Holds the PC stage with `stall_req` until `inst_valid` is pulsed to the decode stage.

## Interface
Parameters:
- `ADDR_W`, 17 — byte-address width of the instruction RAM (128 KiB).

Ports:
- `clk`  in  1  — sole clock; all state updates on rising edge.
- `rst_n`  in  1  — reset: one clock; reset is asynchronous and active-low.
- `pc`  in  32  — fetch byte address from the PC stage.
- `ce`  in  1  — fetch request enable from the PC stage.
- `inst`  out  32  — assembled instruction; holds last value between fetches.
- `inst_valid`  out  1  — one-cycle pulse: `inst` is new and valid.
- `stall_req`  out  1  — PC stage must hold `pc` while high.
- `mem_addr`  out  ADDR_W  — RAM byte address.
- `mem_rd`  out  1  — RAM read strobe.
- `mem_din`  in  8  — RAM read data, valid exactly one cycle after the `mem_rd` cycle.

## Operation
- States: IDLE, FETCH, LAST, DONE.
- IDLE:
  - `ce`=1 at an edge → latch `pc_q`=`pc`, beat counter `cnt`=0, go to FETCH.
  - `ce`=0 → stay in IDLE.
- FETCH:
  - `mem_rd`=1, `mem_addr`=`pc_q[ADDR_W-1:0]` + `cnt`; address addition wraps modulo 2^ADDR_W.
  - From the second FETCH cycle on, capture `mem_din` into byte lane `cnt`-1.
  - At `cnt`=3 go to LAST; otherwise `cnt`++.
- LAST:
  - `mem_rd`=0; capture `mem_din` into lane 3.
  - Write `inst`={lane3, lane2, lane1, lane0}; go to DONE.
- DONE: `inst_valid`=1 for this cycle only; go to IDLE unconditionally.
- `stall_req`=1 in FETCH and LAST, 0 in IDLE and DONE. The PC stage advances at the edge ending DONE, and IDLE samples the new `pc`.
- `pc[1:0]` is not checked; an unaligned `pc` fetches the four bytes starting at `pc` as addressed.
- `pc` bits above ADDR_W are ignored.
- Abort: `ce`=0 sampled in FETCH or LAST → go to IDLE, no `inst_valid`, `inst` unchanged, partial lanes discarded.
- `pc` changes while `stall_req`=1 are ignored; `pc_q` is authoritative.
- Reset (any state, any cycle): state=IDLE, `cnt`=0, `pc_q`=0, lanes=0, `inst`=0, `inst_valid`=0, `stall_req`=0, `mem_rd`=0, `mem_addr`=0.

## Timing
- T0: IDLE, `ce`=1, `pc`=P sampled at the edge ending T0.
- T1..T4: FETCH, `mem_rd`=1, `mem_addr`=P..P+3.
- T2..T5: `mem_din` carries bytes 0..3.
- T5: LAST.
- T6: DONE, `inst_valid`=1, `inst` valid. Request-to-valid latency is 6 cycles.
- T7: IDLE. Sustained throughput is one instruction per 7 cycles.
- `mem_rd`, `mem_addr`, `stall_req` and `inst_valid` are decoded from registered state/`cnt` only; no combinational path from `pc`/`ce` to any output.
- `inst` changes only at the edge entering DONE.

## Structure
- Shared `defs.v` gets:
  - fetch-state encodings (`FetchIdle`, `FetchBusy`, `FetchLast`, `FetchDone`, 2-bit);
  - `InstMemAddrW`=17;
  - `RstActiveLow`.
- Existing shared constants (`ZeroWord`, `InstAddrBus`, `InstBus`) are reused.
- Single module; no sub-module. Byte-lane capture is four enabled 8-bit registers.

## Test plan
- Basic fetch: RAM[0..3]=13 05 00 00, `ce`=1, `pc`=0 → `mem_addr` 0,1,2,3 in T1..T4; `inst`=32'h00000513 with `inst_valid` pulse in T6; `stall_req` high T1..T5 only.
- Back-to-back: RAM[4..7]=93 05 10 00; PC stage advances `pc` to 4 after DONE → second `inst`=32'h00100593 exactly 7 cycles after the first `inst_valid`.
- Wrap-around: `pc`=32'h0001FFFE, RAM[1FFFE,1FFFF,0,1]=AA BB CC DD → `mem_addr` sequence 1FFFE,1FFFF,0,1; `inst`=32'hDDCCBBAA.
- Abort: drop `ce` in T3 → state IDLE next cycle; no `inst_valid`; `inst` keeps its previous value; `mem_rd` low from T4.
- Async reset mid-fetch: assert `rst_n`=0 between edges during T2 → all outputs 0 immediately, before the next edge. After release with `ce`=1, `pc`=8, a clean fetch from 8 completes in 6 cycles.
- Stable-`pc` check: toggle `pc` to random values during T1..T5 → `mem_addr` still P..P+3 and `inst` from P.
